// File: rtl/mux4way16_rr_arbiter.sv
// Round-robin owner of a shared 16-bit 4:1 mux; a grant lasts one packet
// or MAX_BURST beats, whichever ends first, then an arbitration bubble.
module mux4way16_rr_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic        busy
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic [15:0]      w_mux;
    logic             w_granted;
    logic             w_valid;
    logic             w_xfer;
    logic             w_release;

    // Scan from the highest offset down so the closest requester to ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_mux = d0;
        unique case (r_sel)
            2'd0: w_mux = d0;
            2'd1: w_mux = d1;
            2'd2: w_mux = d2;
            2'd3: w_mux = d3;
        endcase
    end

    // Outputs are gated by rst_n so nothing is acknowledged while in reset.
    assign w_granted = rst_n && (r_state == S_GRANT);
    assign w_valid   = w_granted && req[r_sel];
    assign w_xfer    = w_valid && out_ready;
    assign w_release = (w_xfer && (last[r_sel] || (r_cnt == LAST_BEAT)))
                     || (w_granted && !req[r_sel]);

    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_mux : 16'h0000;
    assign ack       = w_xfer ? (4'b0001 << r_sel) : 4'b0000;
    assign grant     = w_granted ? (4'b0001 << r_sel) : 4'b0000;
    assign sel       = r_sel;
    assign busy      = w_granted;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux4way16_rr_arbiter.sv
// Scoreboard bench for the round-robin mux arbiter (MAX_BURST=4 instance).
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_mux4way16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] d0, d1, d2, d3;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        busy;

    mux4way16_rr_arbiter #(
        .MAX_BURST (4),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack       (ack),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy)
    );

    typedef struct packed {
        logic [3:0]  ack;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   n_pass;
    int   n_total;
    int   n_xfer;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        e.ack  = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant == exp) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, grant, exp);
        if (!seen) $display("FAIL %s: grant wait timed out", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got data %0h ack %0h, want none",
                         out_data, ack);
            end else begin
                e = q.pop_front();
                check("sb_data", out_data, e.data);
                check("sb_ack", ack, e.ack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    logic [3:0] rr_exp[10];
    logic [3:0] gseq[$];
    logic [3:0] a_s, g_s, g_prev;
    int         idx1;
    logic       done3;
    int         x0;

    initial begin
        n_pass = 0; n_total = 0; n_xfer = 0;
        rst_n = 1'b0; req = 4'hF; last = 4'h0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;

        // Reset with all requests pending
        repeat (2) begin
            @(negedge clk);
            check("rst_grant", grant, 4'h0);
            check("rst_valid", out_valid, 1'b0);
            check("rst_data", out_data, 16'h0);
        end
        step(); rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", grant, 4'h0);
        @(negedge clk);
        check("first_grant", grant, 4'b0001);
        check("first_sel", sel, 2'd0);
        check("first_busy", busy, 1'b1);

        // Single 3-beat packet from requester 2
        step();
        req = 4'b0100; out_ready = 1'b1; d2 = 16'hA001;
        push(4'b0100, 16'hA001);
        push(4'b0100, 16'hA002);
        push(4'b0100, 16'hA003);
        wait_grant(4'b0100, "pkt_grant");
        step(); d2 = 16'hA002; @(negedge clk);
        step(); d2 = 16'hA003; last = 4'b0100; @(negedge clk);
        step(); req = 4'h0; last = 4'h0;
        @(negedge clk);
        check("pkt_release", grant, 4'h0);
        check("pkt_busy", busy, 1'b0);
        check("pkt_sel_hold", sel, 2'd2);

        // Round robin starting at ptr=3 with 1-beat packets
        step();
        req = 4'hF; last = 4'hF;
        d0 = 16'hC000; d1 = 16'hC001; d2 = 16'hC002; d3 = 16'hC003;
        push(4'b1000, 16'hC003);
        push(4'b0001, 16'hC000);
        push(4'b0010, 16'hC001);
        push(4'b0100, 16'hC002);
        push(4'b1000, 16'hC003);
        rr_exp = '{4'h0, 4'h8, 4'h0, 4'h1, 4'h0,
                   4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("rr_grant%0d", i), grant, rr_exp[i]);
        end
        step(); req = 4'h0; last = 4'h0;

        // Burst limit: requester 1 streams 10 beats, requester 3 one packet
        for (int i = 0; i < 10; i++) begin
            if (i == 4) push(4'b1000, 16'hD003);
            push(4'b0010, 16'hB001 + 16'(i));
        end
        idx1 = 0; done3 = 1'b0; g_prev = 4'h0;
        for (int c = 0; c < 60; c++) begin
            if (idx1 == 10 && done3) break;
            req[1] = (idx1 < 10);
            d1     = 16'hB001 + 16'(idx1);
            req[3] = !done3;
            d3     = 16'hD003;
            last   = 4'b1000;
            @(negedge clk);
            a_s = ack; g_s = grant;
            if (g_s != 4'h0 && g_prev == 4'h0) gseq.push_back(g_s);
            g_prev = g_s;
            step();
            if (a_s[1]) idx1++;
            if (a_s[3]) done3 = 1'b1;
        end
        req = 4'h0; last = 4'h0;
        check("burst_done", {idx1[7:0], 7'd0, done3}, {8'd10, 7'd0, 1'b1});
        check("burst_ngrants", gseq.size(), 4);
        if (gseq.size() == 4) begin
            check("burst_g0", gseq[0], 4'b0010);
            check("burst_g1", gseq[1], 4'b1000);
            check("burst_g2", gseq[2], 4'b0010);
            check("burst_g3", gseq[3], 4'b0010);
        end

        // Backpressure on requester 0
        req = 4'b0001; out_ready = 1'b0; d0 = 16'h1111;
        push(4'b0001, 16'h1111);
        push(4'b0001, 16'h2222);
        x0 = n_xfer;
        wait_grant(4'b0001, "bp_grant");
        step(); out_ready = 1'b1; @(negedge clk);
        step(); d0 = 16'h2222; last = 4'b0001; out_ready = 1'b0;
        @(negedge clk);
        check("bp_ack", ack, 4'h0);
        check("bp_data", out_data, 16'h2222);
        check("bp_valid", out_valid, 1'b1);
        step(); @(negedge clk);
        check("bp_ack2", ack, 4'h0);
        check("bp_hold_grant", grant, 4'b0001);
        step(); out_ready = 1'b1; @(negedge clk);
        step(); req = 4'h0; last = 4'h0; out_ready = 1'b0;
        @(negedge clk);
        check("bp_xfers", n_xfer - x0, 2);
        check("bp_release", grant, 4'h0);

        // Abandon by requester 2, then ptr=3 favours 3 over 0
        step(); req = 4'b0100; d2 = 16'h0;
        wait_grant(4'b0100, "ab_grant");
        step(); req = 4'h0;
        @(negedge clk);
        check("ab_valid", out_valid, 1'b0);
        step(); @(negedge clk);
        check("ab_idle", grant, 4'h0);
        step(); req = 4'b1001; d3 = 16'hE001;
        @(negedge clk);
        check("ab_bubble", grant, 4'h0);
        step(); @(negedge clk);
        check("ab_ptr", grant, 4'b1000);

        // Reset in the middle of a packet
        step(); out_ready = 1'b1; last = 4'h0;
        push(4'b1000, 16'hE001);
        @(negedge clk);
        step(); rst_n = 1'b0;
        @(negedge clk);
        check("mrst_ack", ack, 4'h0);
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_grant", grant, 4'h0);
        check("mrst_data", out_data, 16'h0);
        step(); rst_n = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("mrst_idle", grant, 4'h0);
        check("mrst_sel", sel, 2'd0);
        check("mrst_busy", busy, 1'b0);
        step(); @(negedge clk);
        check("mrst_ptr", grant, 4'b0001);

        step(); req = 4'h0;
        repeat (3) @(negedge clk);
        check("sb_drain", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
